// File: rtl/bt_packet_rx_if.sv
// Joystick link bus: raw UART line into the receiver, decoded control word out.
interface bt_packet_rx_if;
  localparam int unsigned DATA_W = 20;

  logic              rx;
  logic              rx_vld;
  logic [DATA_W-1:0] rx_data;
  logic              frm_err;

  modport master (input rx, output rx_vld, output rx_data, output frm_err);
  modport slave  (output rx, input rx_vld, input rx_data, input frm_err);
endinterface

// File: rtl/bt_packet_rx.sv
// 8N1 UART receiver that assembles three framed bytes into a 20-bit {X,Y}
// joystick word; incomplete, mis-framed or timed-out packets are dropped.
module bt_packet_rx #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned GAP_BITS = 20,
  parameter logic [3:0]  MARKER   = 4'hA
) (
  input  logic           clk1,
  input  logic           RST,
  bt_packet_rx_if.master bus
);
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned GAP_LIMIT    = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W        = $clog2(GAP_LIMIT + 1);

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [1:0] P_HUNT = 2'd0;
  localparam logic [1:0] P_GOT0 = 2'd1;
  localparam logic [1:0] P_GOT1 = 2'd2;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       bit_st_q, bit_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       pkt_st_q, pkt_st_d;
  logic [3:0]       x_hi_q, x_hi_d;
  logic [7:0]       b1_q, b1_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rx_vld_q, rx_vld_d;
  logic [19:0]      rx_data_q, rx_data_d;
  logic             frm_err_q, frm_err_d;

  logic fall_c, byte_done_c, stop_bad_c;

  assign fall_c = rx_prev_q & ~rx_sync_q;

  // State register; synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk1) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      bit_st_q  <= B_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      pkt_st_q  <= P_HUNT;
      x_hi_q    <= '0;
      b1_q      <= '0;
      gap_q     <= '0;
      rx_vld_q  <= 1'b0;
      rx_data_q <= '0;
      frm_err_q <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      bit_st_q  <= bit_st_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      pkt_st_q  <= pkt_st_d;
      x_hi_q    <= x_hi_d;
      b1_q      <= b1_d;
      gap_q     <= gap_d;
      rx_vld_q  <= rx_vld_d;
      rx_data_q <= rx_data_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Bit FSM: centre-samples start, eight data bits LSB first, then stop.
  always_comb begin
    bit_st_d    = bit_st_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_done_c = 1'b0;
    stop_bad_c  = 1'b0;
    case (bit_st_q)
      B_IDLE: begin
        cnt_d = '0;
        if (fall_c) bit_st_d = B_START;
      end
      B_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          bit_st_d  = rx_sync_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) bit_st_d = B_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d       = '0;
          byte_done_c = rx_sync_q;
          stop_bad_c  = ~rx_sync_q;
          bit_st_d    = B_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Packet FSM with inter-byte gap timeout; timeout beats a coincident start edge.
  always_comb begin
    pkt_st_d  = pkt_st_q;
    x_hi_d    = x_hi_q;
    b1_d      = b1_q;
    gap_d     = gap_q;
    rx_vld_d  = 1'b0;
    rx_data_d = rx_data_q;
    frm_err_d = stop_bad_c;

    if (pkt_st_q == P_HUNT) begin
      gap_d = '0;
    end else if (gap_q == GAP_W'(GAP_LIMIT)) begin
      pkt_st_d = P_HUNT;
      gap_d    = '0;
    end else if (bit_st_q == B_IDLE) begin
      gap_d = fall_c ? '0 : gap_q + GAP_W'(1);
    end

    if (stop_bad_c) begin
      pkt_st_d = P_HUNT;
    end else if (byte_done_c) begin
      case (pkt_st_q)
        P_HUNT: begin
          if (shift_q[7:4] == MARKER) begin
            x_hi_d   = shift_q[3:0];
            pkt_st_d = P_GOT0;
          end
        end
        P_GOT0: begin
          b1_d     = shift_q;
          pkt_st_d = P_GOT1;
        end
        default: begin
          rx_data_d = {x_hi_q, b1_q, shift_q};
          rx_vld_d  = 1'b1;
          pkt_st_d  = P_HUNT;
        end
      endcase
    end
  end

  assign bus.rx_vld  = rx_vld_q;
  assign bus.rx_data = rx_data_q;
  assign bus.frm_err = frm_err_q;
endmodule

// File: tb/tb_bt_packet_rx.sv
// Randomized bench for bt_packet_rx: a byte-level packet model predicts every
// rx_vld/frm_err pulse and the held rx_data, checked on every clock.
module tb_bt_packet_rx;
  localparam int unsigned CLK_HZ   = 153_600;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned GAP_BITS = 20;
  localparam int unsigned CPB      = CLK_HZ / BAUD;
  localparam int unsigned HALF     = CPB / 2;
  localparam logic [3:0]  MARKER   = 4'hA;

  logic clk1 = 1'b0;
  logic RST;

  bt_packet_rx_if bus();

  bt_packet_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_BITS(GAP_BITS), .MARKER(MARKER)
  ) dut (
    .clk1(clk1),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic prev_vld = 1'b0;
  logic [19:0] exp_data = '0;
  int          vld_dl[$];
  logic [19:0] vld_val[$];
  int          err_dl[$];

  int         m_st = 0;
  logic [7:0] m_b0 = '0;
  logic [7:0] m_b1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2);
    int x, y;
    x = int'(b0 % 16) * 64 + int'(b1) / 4;
    y = int'(b1 % 4) * 256 + int'(b2);
    return 20'(x * 1024 + y);
  endfunction

  // Byte-level packet rules; called when the stop bit of byte b starts.
  task automatic model_byte(input logic [7:0] b, input int gap, input bit ok);
    if (m_st != 0 && gap >= int'(GAP_BITS)) m_st = 0;
    if (!ok) begin
      err_dl.push_back(cyc + int'(CPB) + 3);
      m_st = 0;
    end else begin
      case (m_st)
        0: if (b[7:4] == MARKER) begin m_b0 = b; m_st = 1; end
        1: begin m_b1 = b; m_st = 2; end
        default: begin
          vld_dl.push_back(cyc + int'(CPB) + 3);
          vld_val.push_back(pack(m_b0, m_b1, b));
          m_st = 0;
        end
      endcase
    end
  endtask

  // Compare process: every output checked against the model each cycle.
  always @(negedge clk1) begin
    cyc++;
    if (RST) begin
      vld_dl.delete();
      vld_val.delete();
      err_dl.delete();
      exp_data = '0;
      prev_vld = 1'b0;
    end else begin
      if (bus.rx_vld) begin
        vld_cnt++;
        chk("vld_back_to_back", 32'(prev_vld), 32'd0);
        chk("vld_with_frm_err", 32'(bus.frm_err), 32'd0);
        checks++;
        if (vld_dl.size() == 0) begin
          errors++;
          $display("FAIL vld_unexpected: got rx_vld=1 with data %0h, expected no packet", bus.rx_data);
        end else begin
          if (cyc > vld_dl[0]) begin
            errors++;
            $display("FAIL vld_late: got cycle %0d expected by %0d", cyc, vld_dl[0]);
          end
          exp_data = vld_val[0];
          void'(vld_dl.pop_front());
          void'(vld_val.pop_front());
        end
      end
      chk("rx_data", 32'(bus.rx_data), 32'(exp_data));
      if (bus.frm_err) begin
        err_cnt++;
        checks++;
        if (err_dl.size() == 0) begin
          errors++;
          $display("FAIL frm_err_unexpected: got frm_err=1 expected 0");
        end else begin
          void'(err_dl.pop_front());
        end
      end
      if (vld_dl.size() != 0 && cyc > vld_dl[0]) begin
        checks++;
        errors++;
        $display("FAIL vld_missing: got no pulse expected data %0h by cycle %0d", vld_val[0], vld_dl[0]);
        void'(vld_dl.pop_front());
        void'(vld_val.pop_front());
      end
      if (err_dl.size() != 0 && cyc > err_dl[0]) begin
        checks++;
        errors++;
        $display("FAIL frm_err_missing: got no pulse expected one by cycle %0d", err_dl[0]);
        void'(err_dl.pop_front());
      end
      prev_vld = bus.rx_vld;
    end
  end

  // Stimulus helpers: entered and left at posedge+1.
  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit ok);
    if (gap > 0) drive(1'b1, gap * int'(CPB));
    drive(1'b0, int'(CPB));
    for (int i = 0; i < 8; i++) drive(b[i], int'(CPB));
    model_byte(b, gap, ok);
    drive(ok, int'(CPB));
    if (!ok) drive(1'b1, int'(CPB));
  endtask

  task automatic pulse_reset();
    RST  = 1'b1;
    m_st = 0;
    @(posedge clk1);
    #1;
    RST = 1'b0;
  endtask

  task automatic expect_result(input string name, input int v0, input int e0,
                               input int nv, input int ne, input logic [19:0] data);
    drive(1'b1, 2 * int'(CPB));
    @(negedge clk1);
    chk({name, "_vld_count"}, 32'(vld_cnt - v0), 32'(nv));
    chk({name, "_err_count"}, 32'(err_cnt - e0), 32'(ne));
    chk({name, "_data"}, 32'(bus.rx_data), 32'(data));
    @(posedge clk1);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish within 1 ms");
    $fatal(1, "bench timeout");
  end

  initial begin
    int v0, e0, g;
    logic [7:0] b;
    bit ok;

    bus.rx = 1'b1;
    RST    = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    RST = 1'b0;
    @(negedge clk1);
    chk("reset_rx_vld", 32'(bus.rx_vld), 32'd0);
    chk("reset_frm_err", 32'(bus.frm_err), 32'd0);
    chk("reset_rx_data", 32'(bus.rx_data), 32'h0);
    chk("model_pin_7d1f1", 32'(pack(8'hA7, 8'hD1, 8'hF1)), 32'h7D1F1);
    chk("model_pin_fffff", 32'(pack(8'hAF, 8'hFF, 8'hFF)), 32'hFFFFF);
    @(posedge clk1);
    #1;
    drive(1'b1, 2 * int'(CPB));

    // Back-to-back packet
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hA7, 0, 1'b1);
    send_byte(8'hD1, 0, 1'b1);
    send_byte(8'hF1, 0, 1'b1);
    expect_result("t1", v0, e0, 1, 0, 20'h7D1F1);

    // Non-marker byte dropped while hunting
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'h37, 0, 1'b1);
    send_byte(8'hA0, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    expect_result("t2", v0, e0, 1, 0, 20'h00000);

    // Gap timeout abandons the first packet
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hA7, 0, 1'b1);
    send_byte(8'hD1, 0, 1'b1);
    send_byte(8'hF1, 21, 1'b1);
    send_byte(8'hAF, 0, 1'b1);
    send_byte(8'hFF, 0, 1'b1);
    send_byte(8'hFF, 0, 1'b1);
    expect_result("t3", v0, e0, 1, 0, 20'hFFFFF);

    // Framing errors, including one that aborts a partial packet
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hA7, 0, 1'b0);
    send_byte(8'hA7, 1, 1'b1);
    send_byte(8'hD1, 0, 1'b0);
    send_byte(8'hA7, 1, 1'b1);
    send_byte(8'hD1, 0, 1'b1);
    send_byte(8'hF1, 0, 1'b1);
    expect_result("t4", v0, e0, 1, 2, 20'h7D1F1);

    // Short low glitches on an idle line
    v0 = vld_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i == 0) ? 1 : (i == 1) ? 3 : int'(HALF) - 2);
      drive(1'b1, 2 * int'(CPB));
    end
    send_byte(8'hA3, 0, 1'b1);
    send_byte(8'h45, 0, 1'b1);
    send_byte(8'h67, 0, 1'b1);
    expect_result("t5", v0, e0, 1, 0, 20'h34567);

    // Reset mid-packet
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hA7, 0, 1'b1);
    send_byte(8'hD1, 0, 1'b1);
    pulse_reset();
    @(negedge clk1);
    chk("t6_reset_data", 32'(bus.rx_data), 32'h0);
    chk("t6_reset_vld", 32'(bus.rx_vld), 32'd0);
    @(posedge clk1);
    #1;
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hA7, 1, 1'b1);
    send_byte(8'hD1, 0, 1'b1);
    send_byte(8'hF1, 0, 1'b1);
    expect_result("t6", v0, e0, 1, 0, 20'h7D1F1);

    // Random byte stream with marker bias, long/short gaps and bad stops
    for (int n = 0; n < 90; n++) begin
      b  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {MARKER, 4'($urandom)};
      g  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(22, 26)) : int'($urandom_range(0, 3));
      ok = ($urandom_range(0, 11) != 0);
      send_byte(b, g, ok);
    end
    drive(1'b1, 3 * int'(CPB));
    @(negedge clk1);
    chk("end_vld_pending", 32'(vld_dl.size()), 32'd0);
    chk("end_err_pending", 32'(err_dl.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
